// File: rtl/bram_stream_reader_pkg.sv
// Shared constants for the BRAM stream reader: FSM encoding and
// the depth of the return-data FIFO that sets the read credit limit.
package bram_stream_reader_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam int FIFO_DEPTH = 2;
  localparam int FIFO_CW    = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/bram_stream_reader_fifo.sv
// Two-entry synchronous FIFO holding returned BRAM words (plus last tag).
// The head is always presented on dout; count tells the reader how many
// entries are valid. Overflow is prevented by the reader's credit check.
module bram_rd_fifo
  import bram_stream_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic [W-1:0]       din,
  input  logic               pop,
  output logic [W-1:0]       dout,
  output logic [FIFO_CW-1:0] count
);

  logic [W-1:0] mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;

  assign dout = mem[rd_ptr];

  // Storage, pointers and occupancy; reset clears the entries so the head reads zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Read-side BRAM master: on start, reads len consecutive words (wrapping at
// MEM_SIZE) through one BRAM port and streams them out as valid/ready beats.
//
// Handshake: a beat transfers in any cycle where m_valid and m_ready are both
// high; m_valid never depends on m_ready, and m_data/m_last stay fixed while a
// beat is offered but not taken.
//
// addr0 is a register holding the address of the next read. ce0 is decoded
// from registered state plus this cycle's pop, so the credit check
// (fifo_count + inflight - pop < 2) can see a same-cycle accept; that is what
// lets a 2-entry FIFO sustain one beat per cycle without ever overflowing.
module bram_stream_reader
  import bram_stream_reader_pkg::*;
#(
  parameter int DWIDTH   = 16,
  parameter int AWIDTH   = 12,
  parameter int MEM_SIZE = 3840
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH:0]   len,
  output logic              busy,
  output logic              done,
  output logic [AWIDTH-1:0] addr0,
  output logic              ce0,
  output logic              we0,
  output logic [DWIDTH-1:0] d0,
  input  logic [DWIDTH-1:0] q0,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready,
  output logic [1:0]        dbg_state
);

  localparam logic [AWIDTH-1:0] ADDR_ONE  = AWIDTH'(1);
  localparam logic [AWIDTH-1:0] ADDR_LAST = AWIDTH'(MEM_SIZE - 1);
  localparam logic [AWIDTH:0]   CNT_ONE   = (AWIDTH + 1)'(1);

  logic [1:0]         state;
  logic [AWIDTH:0]    len_q;
  logic [AWIDTH:0]    issued_cnt;
  logic [AWIDTH:0]    acc_cnt;
  logic               inflight;
  logic               inflight_last;
  logic [FIFO_CW-1:0] fifo_count;
  logic [DWIDTH:0]    fifo_dout;
  logic               pop;
  logic               credit_ok;
  logic               issue;
  logic               issue_last;
  logic               final_beat;
  logic [AWIDTH-1:0]  addr_next;

  assign we0       = 1'b0;
  assign d0        = '0;
  assign dbg_state = state;
  assign busy      = (state != ST_IDLE);

  assign m_valid = (fifo_count != '0);
  assign m_data  = fifo_dout[DWIDTH-1:0];
  assign m_last  = fifo_dout[DWIDTH];
  assign pop     = m_valid & m_ready;

  assign credit_ok  = ({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  assign issue      = (state == ST_RUN) & credit_ok;
  assign issue_last = issue & (issued_cnt == (len_q - CNT_ONE));
  assign final_beat = (state == ST_DRAIN) & pop & (acc_cnt == (len_q - CNT_ONE));
  assign ce0        = issue;
  assign addr_next  = (addr0 == ADDR_LAST) ? '0 : addr0 + ADDR_ONE;

  bram_rd_fifo #(
    .W(DWIDTH + 1)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .din   ({inflight_last, q0}),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // Job FSM, address walk, issue/accept counters and the one-deep read pipeline tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      len_q         <= '0;
      issued_cnt    <= '0;
      acc_cnt       <= '0;
      addr0         <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      done          <= 1'b0;
    end else begin
      done          <= 1'b0;
      inflight      <= issue;
      inflight_last <= issue_last;
      if (pop) acc_cnt <= acc_cnt + CNT_ONE;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (len == '0) begin
              done <= 1'b1;
            end else begin
              state      <= ST_RUN;
              len_q      <= len;
              addr0      <= base_addr;
              issued_cnt <= '0;
              acc_cnt    <= '0;
            end
          end
        end
        ST_RUN: begin
          if (issue) begin
            addr0      <= addr_next;
            issued_cnt <= issued_cnt + CNT_ONE;
            if (issue_last) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (final_beat) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: BRAM model with mem[i]=i, scoreboard of
// expected beats and read addresses, directed and random jobs.
module tb_bram_stream_reader;
  import bram_stream_reader_pkg::*;

  localparam int DW  = 16;
  localparam int AW  = 12;
  localparam int MSZ = 3840;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   len;
  logic          busy, done, ce0, we0, m_valid, m_last;
  logic          m_ready;
  logic [AW-1:0] addr0;
  logic [DW-1:0] d0, q0, m_data;
  logic [1:0]    dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bram_stream_reader #(.DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MSZ)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .addr0(addr0), .ce0(ce0), .we0(we0), .d0(d0),
    .q0(q0), .m_data(m_data), .m_valid(m_valid), .m_last(m_last),
    .m_ready(m_ready), .dbg_state(dbg_state)
  );

  // BRAM model, 1-cycle read latency
  logic [DW-1:0] mem [MSZ];
  initial for (int i = 0; i < MSZ; i++) mem[i] = DW'(i);
  always @(posedge clk) if (ce0 && addr0 < AW'(MSZ)) q0 <= mem[addr0];

  // ---------------- scoreboard ----------------
  logic [DW:0]   exp_q[$];
  logic [AW-1:0] addr_q[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  int ce_total = 0, valid_total = 0, beat_cnt = 0, done_cnt = 0;
  int outstanding = 0, last_beat_cyc = -10, done_cyc = -10;
  logic prev_stall = 1'b0;
  logic [DW:0] prev_beat;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (ce0) begin
        ce_total++;
        outstanding++;
        check("addr_range", 32'(addr0 < AW'(MSZ)), 1);
        if (addr_q.size() == 0) check("unexpected_read", 1, 0);
        else check("read_addr", 32'(addr0), 32'(addr_q.pop_front()));
      end
      if (m_valid) valid_total++;
      if (prev_stall) begin
        check("stall_valid", 32'(m_valid), 1);
        check("stall_data", 32'({m_last, m_data}), 32'(prev_beat));
      end
      if (m_valid && m_ready) begin
        logic [DW:0] e;
        outstanding--;
        beat_cnt++;
        if (m_last) last_beat_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("beat_data", 32'(m_data), 32'(e[DW-1:0]));
          check("beat_last", 32'(m_last), 32'(e[DW]));
        end
      end
      if (ce0) check("credit", 32'(outstanding <= 2), 1);
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = m_valid & ~m_ready;
      prev_beat  = {m_last, m_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; m_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_ce0", 32'(ce0), 0);
    check("rst_we0", 32'(we0), 0);
    check("rst_addr0", 32'(addr0), 0);
    check("rst_valid", 32'(m_valid), 0);
    check("rst_last", 32'(m_last), 0);
    check("rst_data", 32'(m_data), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
  endtask

  // Pulses start for one cycle; returns 1ns into cycle T+1.
  task automatic start_job(input int b, input int n);
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(b); len = (AW + 1)'(n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({(i == n - 1), DW'((b + i) % MSZ)});
      addr_q.push_back(AW'((b + i) % MSZ));
    end
    @(posedge clk); #1;
    start = 1'b0;
    base_addr = AW'($urandom_range(0, MSZ - 1));
    len = (AW + 1)'($urandom_range(0, 50));
  endtask

  // mode 0: ready high, 1: pattern 1,0,0,1,0..., 2: random
  task automatic wait_done(input int mode, input int max_cyc);
    int d0c;
    logic pat[5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    d0c = done_cnt;
    for (int i = 0; i < max_cyc; i++) begin
      case (mode)
        0: m_ready = 1'b1;
        1: m_ready = pat[i % 5];
        default: m_ready = 1'($urandom_range(0, 1));
      endcase
      @(posedge clk); #1;
      if (done_cnt != d0c) break;
    end
    check("done_seen", 32'(done_cnt != d0c), 1);
    check("done_latency", 32'(done_cyc), 32'(last_beat_cyc + 1));
    check("busy_after_done", 32'(busy), 0);
    check("queue_drained", 32'(exp_q.size()), 0);
    m_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int c0, v0, d0c, b0;
    do_reset();
    m_ready = 1'b1;

    // basic: base 10, len 4, first-beat latency
    start_job(10, 4);
    check("t1_busy", 32'(busy), 1);
    check("t1_ce0", 32'(ce0), 1);
    check("t1_addr0", 32'(addr0), 10);
    check("t1_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("t2_valid", 32'(m_valid), 0);
    @(posedge clk); #1;
    check("t3_valid", 32'(m_valid), 1);
    check("t3_data", 32'(m_data), 10);
    wait_done(0, 40);

    // wrap across MEM_SIZE
    start_job(MSZ - 2, 4);
    wait_done(0, 40);

    // backpressure pattern
    start_job(50, 8);
    wait_done(1, 200);

    // zero length
    c0 = ce_total; v0 = valid_total; d0c = done_cnt;
    start_job(7, 0);
    check("zl_done", 32'(done), 1);
    check("zl_busy", 32'(busy), 0);
    repeat (5) @(posedge clk);
    #1;
    check("zl_no_read", 32'(ce_total), 32'(c0));
    check("zl_no_beat", 32'(valid_total), 32'(v0));
    check("zl_one_done", 32'(done_cnt), 32'(d0c + 1));

    // start while busy is ignored
    start_job(100, 6);
    @(posedge clk); #1;
    start = 1'b1; base_addr = 12'd500; len = 13'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(0, 60);
    repeat (5) @(posedge clk);
    #1;
    check("sb_no_extra", 32'(busy), 0);

    // reset mid-job after 3 of 8 beats
    b0 = beat_cnt; d0c = done_cnt;
    start_job(200, 8);
    for (int i = 0; i < 40; i++) begin
      if (beat_cnt - b0 >= 3) break;
      @(posedge clk); #1;
    end
    check("mid_three_beats", 32'(beat_cnt - b0 >= 3), 1);
    rst = 1'b1;
    exp_q.delete(); addr_q.delete();
    #1;
    check("mid_busy", 32'(busy), 0);
    check("mid_ce0", 32'(ce0), 0);
    check("mid_valid", 32'(m_valid), 0);
    check("mid_last", 32'(m_last), 0);
    check("mid_data", 32'(m_data), 0);
    check("mid_addr0", 32'(addr0), 0);
    check("mid_done", 32'(done), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_no_done", 32'(done_cnt), 32'(d0c));
    start_job(300, 8);
    wait_done(2, 200);

    // random jobs, random backpressure
    for (int j = 0; j < 6; j++) begin
      start_job($urandom_range(0, MSZ - 1), $urandom_range(1, 20));
      wait_done(2, 400);
    end

    check("final_queue", 32'(exp_q.size() + addr_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
